id_ex_register: RTL and testbench

ID_EX_REGISTER -- requirements
Module: id_ex_register

---
 rtl/id_ex_register.sv | 159 +++++++++++++++
 tb/tb_id_ex_register.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_register.sv
// ID/EX pipeline register with load-use hazard detection, flush/hold handling
// and a saturating count of inserted bubbles.
module id_ex_register (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hold,
  input  logic        flush,
  input  logic        IF_ID_valid,
  input  logic [31:0] IF_ID_pc,
  input  logic [31:0] IF_ID_rs1_data,
  input  logic [31:0] IF_ID_rs2_data,
  input  logic [31:0] IF_ID_imm,
  input  logic [4:0]  IF_ID_RegisterRs1,
  input  logic [4:0]  IF_ID_RegisterRs2,
  input  logic [4:0]  IF_ID_RegisterRd,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemtoReg,
  input  logic        ALUSrc,
  input  logic        Branch,
  input  logic [1:0]  ALUOp,
  output logic        ID_EX_valid,
  output logic [31:0] ID_EX_pc,
  output logic [31:0] ID_EX_rs1_data,
  output logic [31:0] ID_EX_rs2_data,
  output logic [31:0] ID_EX_imm,
  output logic [4:0]  ID_EX_RegisterRs1,
  output logic [4:0]  ID_EX_RegisterRs2,
  output logic [4:0]  ID_EX_RegisterRd,
  output logic        ID_EX_RegWrite,
  output logic        ID_EX_MemRead,
  output logic        ID_EX_MemWrite,
  output logic        ID_EX_MemtoReg,
  output logic        ID_EX_ALUSrc,
  output logic        ID_EX_Branch,
  output logic [1:0]  ID_EX_ALUOp,
  output logic        stall_o,
  output logic [15:0] bubble_cnt
);

  typedef struct packed {
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       mem_to_reg;
    logic       alu_src;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  ctrl_t       ctrl_in;
  ctrl_t       ctrl_q, ctrl_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] rs1_data_q, rs1_data_d;
  logic [31:0] rs2_data_q, rs2_data_d;
  logic [31:0] imm_q, imm_d;
  logic [4:0]  rs1_q, rs1_d;
  logic [4:0]  rs2_q, rs2_d;
  logic [4:0]  rd_q, rd_d;
  logic [15:0] cnt_q, cnt_d;
  logic        load_use;

  assign ctrl_in = '{reg_write:  RegWrite,
                     mem_read:   MemRead,
                     mem_write:  MemWrite,
                     mem_to_reg: MemtoReg,
                     alu_src:    ALUSrc,
                     branch:     Branch,
                     alu_op:     ALUOp};

  // A load in EX whose destination is read by the instruction in decode.
  assign load_use = valid_q && ctrl_q.mem_read && (rd_q != 5'd0) &&
                    ((rd_q == IF_ID_RegisterRs1) || (rd_q == IF_ID_RegisterRs2));

  // Hold freezes everything and flush squashes the dependent anyway, so neither stalls.
  assign stall_o = load_use && !hold && !flush;

  always_comb begin
    valid_d    = valid_q;
    ctrl_d     = ctrl_q;
    pc_d       = pc_q;
    rs1_data_d = rs1_data_q;
    rs2_data_d = rs2_data_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    rs2_d      = rs2_q;
    rd_d       = rd_q;
    cnt_d      = cnt_q;
    if (hold) begin
      // retain current contents
    end else if (flush || load_use) begin
      // data/pc fields keep their old contents inside a bubble
      valid_d = 1'b0;
      ctrl_d  = '0;
      rs1_d   = 5'd0;
      rs2_d   = 5'd0;
      rd_d    = 5'd0;
      if (cnt_q != 16'hFFFF) begin
        cnt_d = cnt_q + 16'd1;
      end
    end else begin
      valid_d    = IF_ID_valid;
      ctrl_d     = IF_ID_valid ? ctrl_in : '0;
      pc_d       = IF_ID_pc;
      rs1_data_d = IF_ID_rs1_data;
      rs2_data_d = IF_ID_rs2_data;
      imm_d      = IF_ID_imm;
      rs1_d      = IF_ID_RegisterRs1;
      rs2_d      = IF_ID_RegisterRs2;
      rd_d       = IF_ID_valid ? IF_ID_RegisterRd : 5'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q    <= 1'b0;
      ctrl_q     <= '0;
      pc_q       <= '0;
      rs1_data_q <= '0;
      rs2_data_q <= '0;
      imm_q      <= '0;
      rs1_q      <= '0;
      rs2_q      <= '0;
      rd_q       <= '0;
      cnt_q      <= '0;
    end else begin
      valid_q    <= valid_d;
      ctrl_q     <= ctrl_d;
      pc_q       <= pc_d;
      rs1_data_q <= rs1_data_d;
      rs2_data_q <= rs2_data_d;
      imm_q      <= imm_d;
      rs1_q      <= rs1_d;
      rs2_q      <= rs2_d;
      rd_q       <= rd_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ID_EX_valid       = valid_q;
  assign ID_EX_pc          = pc_q;
  assign ID_EX_rs1_data    = rs1_data_q;
  assign ID_EX_rs2_data    = rs2_data_q;
  assign ID_EX_imm         = imm_q;
  assign ID_EX_RegisterRs1 = rs1_q;
  assign ID_EX_RegisterRs2 = rs2_q;
  assign ID_EX_RegisterRd  = rd_q;
  assign ID_EX_RegWrite    = ctrl_q.reg_write;
  assign ID_EX_MemRead     = ctrl_q.mem_read;
  assign ID_EX_MemWrite    = ctrl_q.mem_write;
  assign ID_EX_MemtoReg    = ctrl_q.mem_to_reg;
  assign ID_EX_ALUSrc      = ctrl_q.alu_src;
  assign ID_EX_Branch      = ctrl_q.branch;
  assign ID_EX_ALUOp       = ctrl_q.alu_op;
  assign bubble_cnt        = cnt_q;

endmodule

// File: tb/tb_id_ex_register.sv
// Randomized and directed bench for id_ex_register against a behavioural
// model of the stage; the model is checked every falling edge.
module tb_id_ex_register;

  logic        clk = 1'b0;
  logic        rst_n, hold, flush, IF_ID_valid;
  logic [31:0] IF_ID_pc, IF_ID_rs1_data, IF_ID_rs2_data, IF_ID_imm;
  logic [4:0]  IF_ID_RegisterRs1, IF_ID_RegisterRs2, IF_ID_RegisterRd;
  logic        RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch;
  logic [1:0]  ALUOp;
  logic        ID_EX_valid;
  logic [31:0] ID_EX_pc, ID_EX_rs1_data, ID_EX_rs2_data, ID_EX_imm;
  logic [4:0]  ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd;
  logic        ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg;
  logic        ID_EX_ALUSrc, ID_EX_Branch;
  logic [1:0]  ID_EX_ALUOp;
  logic        stall_o;
  logic [15:0] bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_register dut (
    .clk(clk), .rst_n(rst_n), .hold(hold), .flush(flush),
    .IF_ID_valid(IF_ID_valid), .IF_ID_pc(IF_ID_pc),
    .IF_ID_rs1_data(IF_ID_rs1_data), .IF_ID_rs2_data(IF_ID_rs2_data),
    .IF_ID_imm(IF_ID_imm), .IF_ID_RegisterRs1(IF_ID_RegisterRs1),
    .IF_ID_RegisterRs2(IF_ID_RegisterRs2), .IF_ID_RegisterRd(IF_ID_RegisterRd),
    .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .MemtoReg(MemtoReg), .ALUSrc(ALUSrc), .Branch(Branch), .ALUOp(ALUOp),
    .ID_EX_valid(ID_EX_valid), .ID_EX_pc(ID_EX_pc),
    .ID_EX_rs1_data(ID_EX_rs1_data), .ID_EX_rs2_data(ID_EX_rs2_data),
    .ID_EX_imm(ID_EX_imm), .ID_EX_RegisterRs1(ID_EX_RegisterRs1),
    .ID_EX_RegisterRs2(ID_EX_RegisterRs2), .ID_EX_RegisterRd(ID_EX_RegisterRd),
    .ID_EX_RegWrite(ID_EX_RegWrite), .ID_EX_MemRead(ID_EX_MemRead),
    .ID_EX_MemWrite(ID_EX_MemWrite), .ID_EX_MemtoReg(ID_EX_MemtoReg),
    .ID_EX_ALUSrc(ID_EX_ALUSrc), .ID_EX_Branch(ID_EX_Branch),
    .ID_EX_ALUOp(ID_EX_ALUOp), .stall_o(stall_o), .bubble_cnt(bubble_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Control word of the stage as a plain 8-bit value:
  // {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp}
  logic        m_known = 1'b0;
  logic        m_data_known;
  logic        m_valid;
  logic [7:0]  m_ctrl;
  logic [31:0] m_pc, m_rs1d, m_rs2d, m_imm;
  logic [4:0]  m_rs1, m_rs2, m_rd;
  int          m_cnt;

  function automatic logic m_hazard();
    return m_valid && m_ctrl[6] && (m_rd != 0) &&
           (m_rd == IF_ID_RegisterRs1 || m_rd == IF_ID_RegisterRs2);
  endfunction

  always @(posedge clk) begin
    if (!rst_n) begin
      m_known <= 1'b1; m_data_known <= 1'b1; m_valid <= 1'b0; m_ctrl <= 8'd0;
      m_pc <= 0; m_rs1d <= 0; m_rs2d <= 0; m_imm <= 0;
      m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0; m_cnt <= 0;
    end else if (hold) begin
      // stage frozen
    end else if (flush || m_hazard()) begin
      m_valid <= 1'b0; m_ctrl <= 8'd0; m_rs1 <= 0; m_rs2 <= 0; m_rd <= 0;
      m_data_known <= 1'b0;
      m_cnt <= (m_cnt + 1 > 65535) ? 65535 : m_cnt + 1;
    end else begin
      m_valid <= IF_ID_valid;
      m_ctrl <= IF_ID_valid ? {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp} : 8'd0;
      m_rd <= IF_ID_valid ? IF_ID_RegisterRd : 5'd0;
      m_rs1 <= IF_ID_RegisterRs1; m_rs2 <= IF_ID_RegisterRs2;
      m_pc <= IF_ID_pc; m_rs1d <= IF_ID_rs1_data; m_rs2d <= IF_ID_rs2_data; m_imm <= IF_ID_imm;
      m_data_known <= 1'b1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("valid", {31'd0, ID_EX_valid}, {31'd0, m_valid});
      chk("ctrl", {24'd0, ID_EX_RegWrite, ID_EX_MemRead, ID_EX_MemWrite, ID_EX_MemtoReg,
                   ID_EX_ALUSrc, ID_EX_Branch, ID_EX_ALUOp}, {24'd0, m_ctrl});
      chk("regs", {17'd0, ID_EX_RegisterRs1, ID_EX_RegisterRs2, ID_EX_RegisterRd},
                  {17'd0, m_rs1, m_rs2, m_rd});
      chk("bubble_cnt", {16'd0, bubble_cnt}, m_cnt);
      chk("stall_o", {31'd0, stall_o}, {31'd0, m_hazard() && !hold && !flush});
      if (m_data_known) begin
        chk("pc", ID_EX_pc, m_pc);
        chk("rs1_data", ID_EX_rs1_data, m_rs1d);
        chk("rs2_data", ID_EX_rs2_data, m_rs2d);
        chk("imm", ID_EX_imm, m_imm);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [4:0] rs1,
                       input logic [4:0] rs2, input logic [4:0] rd, input logic [7:0] ctrl);
    IF_ID_valid = v; IF_ID_pc = pc;
    IF_ID_rs1_data = pc ^ 32'hA5A5_0000; IF_ID_rs2_data = pc + 32'd7; IF_ID_imm = pc << 2;
    IF_ID_RegisterRs1 = rs1; IF_ID_RegisterRs2 = rs2; IF_ID_RegisterRd = rd;
    {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp} = ctrl;
  endtask

  localparam logic [7:0] C_ALU = 8'b1000_0010; // RegWrite, ALUOp=10
  localparam logic [7:0] C_LW  = 8'b1101_1000; // RegWrite, MemRead, MemtoReg, ALUSrc

  initial begin
    rst_n = 1'b0; hold = 1'b0; flush = 1'b0;
    drive(1'b0, 32'd0, 5'd0, 5'd0, 5'd0, 8'd0);
    tick(); tick();
    $display("reset: valid=%0b cnt=%0d stall=%0b", ID_EX_valid, bubble_cnt, stall_o);
    chk("reset valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("reset cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("reset stall", {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1;

    // normal capture
    drive(1'b1, 32'h100, 5'd1, 5'd2, 5'd3, C_ALU);
    tick();
    $display("capture: pc=%0h rd=%0d regwrite=%0b", ID_EX_pc, ID_EX_RegisterRd, ID_EX_RegWrite);
    chk("cap pc", ID_EX_pc, 32'h100);
    chk("cap rd", {27'd0, ID_EX_RegisterRd}, 32'd3);
    chk("cap regwrite", {31'd0, ID_EX_RegWrite}, 32'd1);
    chk("cap stall", {31'd0, stall_o}, 32'd0);

    // load-use on rs2
    drive(1'b1, 32'h104, 5'd1, 5'd2, 5'd5, C_LW);
    tick();
    drive(1'b1, 32'h108, 5'd7, 5'd5, 5'd6, C_ALU);
    #1;
    chk("lu stall", {31'd0, stall_o}, 32'd1);
    tick();
    $display("load-use bubble: valid=%0b regwrite=%0b cnt=%0d", ID_EX_valid, ID_EX_RegWrite, bubble_cnt);
    chk("lu bubble regwrite", {31'd0, ID_EX_RegWrite}, 32'd0);
    chk("lu bubble memread", {31'd0, ID_EX_MemRead}, 32'd0);
    chk("lu cnt", {16'd0, bubble_cnt}, 32'd1);
    chk("lu stall released", {31'd0, stall_o}, 32'd0);
    tick();
    chk("lu dependent pc", ID_EX_pc, 32'h108);
    chk("lu dependent valid", {31'd0, ID_EX_valid}, 32'd1);

    // load to x0 never stalls
    drive(1'b1, 32'h10C, 5'd1, 5'd2, 5'd0, C_LW);
    tick();
    drive(1'b1, 32'h110, 5'd0, 5'd3, 5'd4, C_ALU);
    #1;
    chk("x0 stall", {31'd0, stall_o}, 32'd0);
    tick();
    $display("x0 load: pc=%0h cnt=%0d", ID_EX_pc, bubble_cnt);
    chk("x0 pc", ID_EX_pc, 32'h110);
    chk("x0 cnt", {16'd0, bubble_cnt}, 32'd1);

    // flush together with load-use -> one bubble
    drive(1'b1, 32'h114, 5'd1, 5'd2, 5'd5, C_LW);
    tick();
    drive(1'b1, 32'h118, 5'd5, 5'd2, 5'd7, C_ALU);
    flush = 1'b1;
    #1;
    chk("flush+lu stall", {31'd0, stall_o}, 32'd0);
    tick();
    $display("flush+load-use: valid=%0b cnt=%0d", ID_EX_valid, bubble_cnt);
    chk("flush+lu valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("flush+lu cnt", {16'd0, bubble_cnt}, 32'd2);
    flush = 1'b0;
    tick();
    chk("post flush pc", ID_EX_pc, 32'h118);

    // hold beats flush
    hold = 1'b1; flush = 1'b1;
    drive(1'b1, 32'h11C, 5'd8, 5'd9, 5'd10, C_LW);
    tick();
    $display("hold+flush: pc=%0h valid=%0b cnt=%0d", ID_EX_pc, ID_EX_valid, bubble_cnt);
    chk("hold pc", ID_EX_pc, 32'h118);
    chk("hold valid", {31'd0, ID_EX_valid}, 32'd1);
    chk("hold rd", {27'd0, ID_EX_RegisterRd}, 32'd7);
    chk("hold cnt", {16'd0, bubble_cnt}, 32'd2);
    hold = 1'b0; flush = 1'b0;

    // randomized traffic; small register range makes hazards frequent
    for (int i = 0; i < 3000; i++) begin
      rst_n = ($urandom_range(0, 63) != 0);
      hold  = ($urandom_range(0, 7) == 0);
      flush = ($urandom_range(0, 7) == 0);
      IF_ID_valid = ($urandom_range(0, 5) != 0);
      IF_ID_pc = $urandom; IF_ID_rs1_data = $urandom; IF_ID_rs2_data = $urandom; IF_ID_imm = $urandom;
      IF_ID_RegisterRs1 = 5'($urandom_range(0, 7));
      IF_ID_RegisterRs2 = 5'($urandom_range(0, 7));
      IF_ID_RegisterRd  = 5'($urandom_range(0, 7));
      {RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, ALUOp} = 8'($urandom);
      tick();
    end
    $display("random phase done: cnt=%0d", bubble_cnt);
    rst_n = 1'b1; hold = 1'b0; flush = 1'b0;

    // reset during a stall
    drive(1'b1, 32'h200, 5'd1, 5'd2, 5'd9, C_LW);
    tick();
    drive(1'b1, 32'h204, 5'd9, 5'd2, 5'd11, C_ALU);
    #1;
    chk("mid-stall stall", {31'd0, stall_o}, 32'd1);
    rst_n = 1'b0;
    tick();
    $display("reset mid-stall: valid=%0b pc=%0h cnt=%0d stall=%0b", ID_EX_valid, ID_EX_pc, bubble_cnt, stall_o);
    chk("rst valid", {31'd0, ID_EX_valid}, 32'd0);
    chk("rst pc", ID_EX_pc, 32'd0);
    chk("rst rd", {27'd0, ID_EX_RegisterRd}, 32'd0);
    chk("rst memread", {31'd0, ID_EX_MemRead}, 32'd0);
    chk("rst cnt", {16'd0, bubble_cnt}, 32'd0);
    chk("rst stall", {31'd0, stall_o}, 32'd0);
    rst_n = 1'b1;

    // saturation
    flush = 1'b1;
    repeat (65535) tick();
    chk("sat preload", {16'd0, bubble_cnt}, 32'hFFFF);
    tick();
    $display("saturation: cnt=%0h", bubble_cnt);
    chk("sat hold", {16'd0, bubble_cnt}, 32'hFFFF);
    flush = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
